snake_move_ctrl: RTL and testbench
==================================

# snake_move_ctrl

Movement controller for the snake head. It arbitrates the four direction buttons and the preset load into one registered heading, and rejects 180° reversals. It holds at most one queued turn, generates the periodic step tick, and advances the head coordinate on a wrap-around grid. It sits between the button debouncers and the body/collision logic, and replaces the free-running direction latch as the single owner of heading.

## Interface
Parameters:
- GRID_W, 16, grid width in cells (power of two not required, ≥2)
- GRID_H, 16, grid height in cells (≥2)
- STEP_DIV, 25000000, clk cycles per step while running (≥2)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- set  in  1  preset load (level, sampled each cycle); highest priority
- user_input  in  3  preset heading: 0 right, 1 left, 2 up, 3 down, 4–7 → right
- btn_right, btn_left, btn_up, btn_down  in  1 each  debounced button levels
- pause  in  1  level; freezes stepping while high
- dir_onehot  out  4  {up,down,left,right}, exactly one bit set
- head_x  out  $clog2(GRID_W)  head column
- head_y  out  $clog2(GRID_H)  head row, 0 = top
- step  out  1  one-cycle pulse on each head move
- turn_ack  out  1  one-cycle pulse when a button turn is accepted into the queue
- running  out  1  high in RUN

## Operation
- Heading encoding (2 bits): 00 right, 01 left, 10 up, 11 down. The opposite heading is dir ^ 2'b01.
- Reset values: dir=00 (dir_onehot=4'b0001), head=(GRID_W/2, GRID_H/2), pending empty, counter 0, step=0, turn_ack=0, running=0, state IDLE, button history regs 0.
- Button requests are rising edges of the registered button levels. A button high on the first edge after reset counts as an edge. When several edges occur in the same cycle, priority is right > left > up > down, and only the winner is considered.
- States:
  - IDLE: the first winning button edge loads dir directly, with no reversal check, and enters RUN. No turn_ack is issued. pause is ignored.
  - RUN: the counter increments each cycle. pause high → PAUSE.
  - PAUSE: the counter holds. pause low → RUN. Button requests are still queued.
- set (any state, overrides all other same-cycle events): dir is loaded from user_input, head goes to centre, pending and counter are cleared, and the state becomes RUN. Buttons in that cycle are ignored, but their history registers still update.
- Queue acceptance (RUN/PAUSE): a request is accepted when pending is empty, the request ≠ dir, and the request ≠ dir^1. On acceptance, pending is loaded and turn_ack pulses. Otherwise the request is dropped silently.
- Step (RUN, counter == STEP_DIV-1):
  - The counter returns to 0.
  - If pending is valid, dir takes the pending value and pending clears.
  - The head moves one cell in the new dir.
  - step pulses.
- Wrap-around:
  - x: GRID_W-1 +right → 0; 0 +left → GRID_W-1.
  - y: 0 +up → GRID_H-1; GRID_H-1 +down → 0.
- A request accepted in the same cycle as a step is checked against the pre-step dir and pending. Because pending is being consumed that cycle, the request is accepted only if pending was empty before the step. It is applied at the following step.
- An asynchronous reset mid-operation returns all outputs to their reset values immediately. The pending turn is lost.

## Timing
- All outputs are registered, with no combinational input→output paths.
- Button edge sampled at edge k → turn_ack high for the cycle after k.
- Step period is exactly STEP_DIV cycles in RUN. Cycles spent in PAUSE do not count.
- The first step occurs STEP_DIV cycles after entering RUN via set or an IDLE button.
- dir_onehot, head_x/head_y and step all change on the same edge.

## Structure
- Shared package snake_pkg holds:
  - heading localparams DIR_RIGHT/LEFT/UP/DOWN
  - an opposite-heading function
  - the state enum IDLE/RUN/PAUSE
  - the one-hot bit order
- Sub-module snake_step_timer: a STEP_DIV counter with enable, synchronous clear, and a terminal-count output. Everything else stays in one module.

## Test plan
All scenarios use GRID_W=GRID_H=8 and STEP_DIV=4.
- Reset: hold reset low → dir_onehot=0001, head=(4,4), step=0, turn_ack=0, running=0. Release with no stimulus for 20 cycles → no step.
- set=1, user_input=3'b010 for 1 cycle → running=1, dir_onehot=1000. step every 4 cycles with head_y 3,2,1,0,7 (wrap), head_x stays 4.
- Running right, btn_left edge → no turn_ack, dir unchanged. Then btn_up edge → turn_ack, and dir becomes up at the next step, with the head moving up on that step.
- Running right, btn_up edge then btn_down edge before the step → up accepted, down dropped (queue full). Only one turn is applied.
- pause high for 10 cycles mid-period → no step and the counter holds. After release, the step arrives after the remaining cycles of that period.
- In IDLE, btn_right and btn_up rise in the same cycle → dir right, running=1, no turn_ack. Then assert reset asynchronously mid-period → outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement controller: heading codes,
// one-hot bit positions and the controller state enum.
package snake_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    // dir_onehot is packed {up, down, left, right}
    localparam int OH_RIGHT = 0;
    localparam int OH_LEFT  = 1;
    localparam int OH_DOWN  = 2;
    localparam int OH_UP    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

    function automatic logic [3:0] dir_to_onehot(input logic [1:0] d);
        logic [3:0] oh;
        oh = '0;
        case (d)
            DIR_RIGHT: oh[OH_RIGHT] = 1'b1;
            DIR_LEFT:  oh[OH_LEFT]  = 1'b1;
            DIR_UP:    oh[OH_UP]    = 1'b1;
            default:   oh[OH_DOWN]  = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Step period counter: counts enabled cycles and flags the terminal count,
// wrapping to zero on the same edge.
module snake_step_timer #(
    parameter int STEP_DIV = 25000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int CW = $clog2(STEP_DIV);

    logic [CW-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == CW'(STEP_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake head movement controller: button arbitration with reversal rejection,
// a single-entry turn queue, periodic stepping and wrap-around head position.
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int STEP_DIV = 25000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set,
    input  logic [2:0]                 user_input,
    input  logic                       btn_right,
    input  logic                       btn_left,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       pause,
    output logic [3:0]                 dir_onehot,
    output logic [$clog2(GRID_W)-1:0]  head_x,
    output logic [$clog2(GRID_H)-1:0]  head_y,
    output logic                       step,
    output logic                       turn_ack,
    output logic                       running
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    state_t          r_state;
    logic [1:0]      r_dir;
    logic            r_pend_v;
    logic [1:0]      r_pend_dir;
    logic [XW-1:0]   r_head_x;
    logic [YW-1:0]   r_head_y;
    logic            r_step;
    logic            r_turn_ack;
    logic [3:0]      r_btn_prev;

    logic [3:0]      w_btn;
    logic [3:0]      w_edge;
    logic            w_req_v;
    logic [1:0]      w_req;
    logic            w_accept;
    logic            w_tc_en;
    logic            w_tc;
    logic [1:0]      w_next_dir;

    function automatic logic [XW-1:0] next_x(input logic [XW-1:0] x, input logic [1:0] d);
        logic [XW-1:0] nx;
        nx = x;
        if (d == DIR_RIGHT)
            nx = (x == XW'(GRID_W - 1)) ? '0 : x + XW'(1);
        else if (d == DIR_LEFT)
            nx = (x == '0) ? XW'(GRID_W - 1) : x - XW'(1);
        return nx;
    endfunction

    // Row 0 is the top, so "up" decrements
    function automatic logic [YW-1:0] next_y(input logic [YW-1:0] y, input logic [1:0] d);
        logic [YW-1:0] ny;
        ny = y;
        if (d == DIR_DOWN)
            ny = (y == YW'(GRID_H - 1)) ? '0 : y + YW'(1);
        else if (d == DIR_UP)
            ny = (y == '0) ? YW'(GRID_H - 1) : y - YW'(1);
        return ny;
    endfunction

    function automatic logic [1:0] preset_dir(input logic [2:0] u);
        return u[2] ? DIR_RIGHT : u[1:0];
    endfunction

    assign w_btn  = {btn_down, btn_up, btn_left, btn_right};
    assign w_edge = w_btn & ~r_btn_prev;

    always_comb begin
        w_req_v = |w_edge;
        w_req   = DIR_DOWN;
        if (w_edge[0])
            w_req = DIR_RIGHT;
        else if (w_edge[1])
            w_req = DIR_LEFT;
        else if (w_edge[2])
            w_req = DIR_UP;
    end

    // Checked against pre-step dir and pending, so a turn arriving on a step
    // edge is only taken when the queue was already empty
    assign w_accept = (r_state != IDLE) && !set && w_req_v && !r_pend_v
                      && (w_req != r_dir) && (w_req != opposite(r_dir));

    assign w_tc_en    = (r_state == RUN) && !set;
    assign w_next_dir = r_pend_v ? r_pend_dir : r_dir;

    snake_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_timer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (w_tc_en),
        .i_clr   (set),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_dir      <= DIR_RIGHT;
            r_pend_v   <= 1'b0;
            r_pend_dir <= DIR_RIGHT;
            r_head_x   <= XW'(GRID_W / 2);
            r_head_y   <= YW'(GRID_H / 2);
            r_step     <= 1'b0;
            r_turn_ack <= 1'b0;
            r_btn_prev <= '0;
        end else begin
            r_btn_prev <= w_btn;
            r_step     <= 1'b0;
            r_turn_ack <= 1'b0;
            if (set) begin
                r_state  <= RUN;
                r_dir    <= preset_dir(user_input);
                r_pend_v <= 1'b0;
                r_head_x <= XW'(GRID_W / 2);
                r_head_y <= YW'(GRID_H / 2);
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_req_v) begin
                            r_dir   <= w_req;
                            r_state <= RUN;
                        end
                    end
                    RUN:     if (pause) r_state <= PAUSE;
                    PAUSE:   if (!pause) r_state <= RUN;
                    default: r_state <= IDLE;
                endcase
                if (w_tc) begin
                    r_dir    <= w_next_dir;
                    r_head_x <= next_x(r_head_x, w_next_dir);
                    r_head_y <= next_y(r_head_y, w_next_dir);
                    r_step   <= 1'b1;
                    r_pend_v <= w_accept;
                end else if (w_accept) begin
                    r_pend_v <= 1'b1;
                end
                if (w_accept) begin
                    r_pend_dir <= w_req;
                    r_turn_ack <= 1'b1;
                end
            end
        end
    end

    assign dir_onehot = dir_to_onehot(r_dir);
    assign head_x     = r_head_x;
    assign head_y     = r_head_y;
    assign step       = r_step;
    assign turn_ack   = r_turn_ack;
    assign running    = (r_state == RUN);

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl on an 8x8 grid with a 4-cycle step: a queue-based
// reference model checked every cycle, plus directed literal expectations.
module tb_snake_move_ctrl;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int DIV = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set = 1'b0;
    logic [2:0] user_input = 3'd0;
    logic       btn_right = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] dir_onehot;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic       step;
    logic       turn_ack;
    logic       running;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    snake_move_ctrl #(
        .GRID_W   (W),
        .GRID_H   (H),
        .STEP_DIV (DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .set        (set),
        .user_input (user_input),
        .btn_right  (btn_right),
        .btn_left   (btn_left),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .pause      (pause),
        .dir_onehot (dir_onehot),
        .head_x     (head_x),
        .head_y     (head_y),
        .step       (step),
        .turn_ack   (turn_ack),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Reference model: headings 0 right, 1 left, 2 up, 3 down
    int dxa[4]   = '{1, -1, 0, 0};
    int dya[4]   = '{0, 0, -1, 1};
    int oppa[4]  = '{1, 0, 3, 2};
    int ohpos[4] = '{0, 1, 3, 2};

    int m_mode = M_IDLE;
    int m_dir = 0;
    int m_x = W / 2;
    int m_y = H / 2;
    int m_since = 0;
    int m_q[$];
    int m_prev[4] = '{0, 0, 0, 0};
    int m_step = 0;
    int m_ack = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = M_IDLE; m_dir = 0; m_x = W / 2; m_y = H / 2;
            m_since = 0; m_q.delete(); m_step = 0; m_ack = 0;
            for (int i = 0; i < 4; i++) m_prev[i] = 0;
        end else begin
            int b[4];
            int win;
            bit acc;
            b[0] = int'(btn_right); b[1] = int'(btn_left);
            b[2] = int'(btn_up);    b[3] = int'(btn_down);
            win = -1;
            for (int i = 0; i < 4; i++)
                if (win < 0 && b[i] == 1 && m_prev[i] == 0) win = i;
            for (int i = 0; i < 4; i++) m_prev[i] = b[i];
            m_step = 0;
            m_ack = 0;
            if (set) begin
                m_dir = (user_input > 3) ? 0 : int'(user_input);
                m_x = W / 2; m_y = H / 2;
                m_q.delete(); m_since = 0; m_mode = M_RUN;
            end else if (m_mode == M_IDLE) begin
                if (win >= 0) begin
                    m_dir = win;
                    m_mode = M_RUN;
                end
            end else begin
                acc = (win >= 0) && (m_q.size() == 0) && (win != m_dir) && (win != oppa[m_dir]);
                if (m_mode == M_RUN) begin
                    m_since++;
                    if (m_since == DIV) begin
                        m_since = 0;
                        if (m_q.size() > 0) m_dir = m_q.pop_front();
                        m_x = (m_x + dxa[m_dir] + W) % W;
                        m_y = (m_y + dya[m_dir] + H) % H;
                        m_step = 1;
                    end
                    if (pause) m_mode = M_PAUSE;
                end else if (!pause) begin
                    m_mode = M_RUN;
                end
                if (acc) begin
                    m_q.push_back(win);
                    m_ack = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_onehot", int'(dir_onehot), 1 << ohpos[m_dir]);
            chk("model_head_x", int'(head_x), m_x);
            chk("model_head_y", int'(head_y), m_y);
            chk("model_step", int'(step), m_step);
            chk("model_turn_ack", int'(turn_ack), m_ack);
            chk("model_running", int'(running), (m_mode == M_RUN) ? 1 : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_step(input string name, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!step && n < 40);
        if (!step) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic preset(input logic [2:0] u);
        set = 1'b1;
        user_input = u;
        cyc();
        set = 1'b0;
    endtask

    int ey[5] = '{3, 2, 1, 0, 7};
    int n;
    int seen;

    initial begin
        // Reset held
        repeat (3) cyc();
        chk("rst_onehot", int'(dir_onehot), 4'b0001);
        chk("rst_head_x", int'(head_x), 4);
        chk("rst_head_y", int'(head_y), 4);
        chk("rst_step", int'(step), 0);
        chk("rst_ack", int'(turn_ack), 0);
        chk("rst_running", int'(running), 0);
        cmp_en = 1'b1;
        reset = 1'b1;
        seen = 0;
        repeat (20) begin
            cyc();
            if (step) seen++;
        end
        chk("idle_no_step", seen, 0);

        // Preset up, vertical wrap
        preset(3'b010);
        chk("up_running", int'(running), 1);
        chk("up_onehot", int'(dir_onehot), 4'b1000);
        for (int i = 0; i < 5; i++) begin
            wait_step("up_step", n);
            chk("up_period", n, DIV);
            chk("up_head_y", int'(head_y), ey[i]);
            chk("up_head_x", int'(head_x), 4);
        end

        // Preset left, horizontal wrap
        preset(3'b001);
        chk("left_onehot", int'(dir_onehot), 4'b0010);
        for (int i = 0; i < 5; i++) begin
            wait_step("left_step", n);
            chk("left_head_x", int'(head_x), ey[i]);
            chk("left_head_y", int'(head_y), 4);
        end

        // Out-of-range preset maps to right; reversal dropped, then up queued
        preset(3'b101);
        chk("p5_onehot", int'(dir_onehot), 4'b0001);
        chk("p5_head_x", int'(head_x), 4);
        btn_left = 1'b1;
        cyc();
        btn_left = 1'b0;
        chk("rev_ack", int'(turn_ack), 0);
        chk("rev_onehot", int'(dir_onehot), 4'b0001);
        btn_up = 1'b1;
        cyc();
        btn_up = 1'b0;
        chk("turn_ack", int'(turn_ack), 1);
        chk("turn_dir_held", int'(dir_onehot), 4'b0001);
        cyc();
        chk("turn_ack_pulse", int'(turn_ack), 0);
        wait_step("turn_step", n);
        chk("turn_period", n, 1);
        chk("turn_onehot", int'(dir_onehot), 4'b1000);
        chk("turn_head_x", int'(head_x), 4);
        chk("turn_head_y", int'(head_y), 3);

        // Queue full: second request dropped
        preset(3'b000);
        btn_up = 1'b1;
        cyc();
        btn_up = 1'b0;
        btn_down = 1'b1;
        chk("q_ack1", int'(turn_ack), 1);
        cyc();
        btn_down = 1'b0;
        chk("q_ack2", int'(turn_ack), 0);
        wait_step("q_step1", n);
        chk("q_onehot1", int'(dir_onehot), 4'b1000);
        chk("q_head_y1", int'(head_y), 3);
        wait_step("q_step2", n);
        chk("q_onehot2", int'(dir_onehot), 4'b1000);
        chk("q_head_y2", int'(head_y), 2);

        // Request on the step edge with empty queue: applied one step later
        preset(3'b000);
        repeat (3) cyc();
        btn_up = 1'b1;
        cyc();
        btn_up = 1'b0;
        chk("edge_step", int'(step), 1);
        chk("edge_ack", int'(turn_ack), 1);
        chk("edge_onehot", int'(dir_onehot), 4'b0001);
        chk("edge_head_x", int'(head_x), 5);
        wait_step("edge_next", n);
        chk("edge_period", n, DIV);
        chk("edge_onehot2", int'(dir_onehot), 4'b1000);
        chk("edge_head", int'(head_x) * 8 + int'(head_y), 5 * 8 + 3);

        // Pause for 10 cycles mid-period
        preset(3'b000);
        repeat (2) cyc();
        pause = 1'b1;
        seen = 0;
        repeat (10) begin
            cyc();
            if (step) seen++;
        end
        chk("pause_running", int'(running), 0);
        pause = 1'b0;
        chk("pause_no_step", seen, 0);
        wait_step("pause_step", n);
        chk("pause_remaining", n, 2);
        chk("pause_head_x", int'(head_x), 5);

        // IDLE entry with simultaneous right+up, then async reset mid-operation
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        btn_right = 1'b1;
        btn_up = 1'b1;
        cyc();
        chk("idle_running", int'(running), 1);
        chk("idle_onehot", int'(dir_onehot), 4'b0001);
        chk("idle_ack", int'(turn_ack), 0);
        wait_step("idle_step", n);
        chk("idle_period", n, DIV);
        chk("idle_head_x", int'(head_x), 5);
        #1 reset = 1'b0;
        #1;
        chk("arst_step", int'(step), 0);
        chk("arst_head_x", int'(head_x), 4);
        chk("arst_head_y", int'(head_y), 4);
        chk("arst_running", int'(running), 0);
        chk("arst_onehot", int'(dir_onehot), 4'b0001);
        chk("arst_ack", int'(turn_ack), 0);
        cyc();
        btn_right = 1'b0;
        btn_up = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
